// File: rtl/nway_cache_fsm_if.sv
// nway_cache_fsm_if: CPU-side and memory-side bus bundle for nway_cache_fsm.
//   CPU side : cpu_req/cpu_we/cpu_addr/cpu_byte_mask/cpu_wdata in,
//              cpu_ready/cpu_rdata out (relative to the cache).
//   Mem side : mem_req/mem_we/mem_addr/mem_wblock out,
//              mem_rblock/mem_ack in (relative to the cache).
//   slave  modport : the cache's view.
//   master modport : the environment's view (core + next memory level).
interface nway_cache_fsm_if #(
  parameter int unsigned BLOCK_WORDS = 8,
  parameter int unsigned ADDR_W      = 32
);
  logic                      cpu_req;
  logic                      cpu_we;
  logic [ADDR_W-1:0]         cpu_addr;
  logic [3:0]                cpu_byte_mask;
  logic [31:0]               cpu_wdata;
  logic                      cpu_ready;
  logic [31:0]               cpu_rdata;
  logic                      mem_req;
  logic                      mem_we;
  logic [ADDR_W-1:0]         mem_addr;
  logic [BLOCK_WORDS*32-1:0] mem_wblock;
  logic [BLOCK_WORDS*32-1:0] mem_rblock;
  logic                      mem_ack;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_byte_mask, cpu_wdata, mem_rblock, mem_ack,
    output cpu_ready, cpu_rdata, mem_req, mem_we, mem_addr, mem_wblock
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_byte_mask, cpu_wdata, mem_rblock, mem_ack,
    input  cpu_ready, cpu_rdata, mem_req, mem_we, mem_addr, mem_wblock
  );
endinterface

// File: rtl/nway_cache_fsm.sv
// nway_cache_fsm: blocking set-associative write-back data cache with a
// multi-cycle IDLE/LOOKUP/WB/REFILL controller and true-LRU replacement
// (invalid ways preferred as victims).
//   clock, reset : sole clock, synchronous active-high reset
//   bus          : nway_cache_fsm_if.slave (CPU request/ready, memory req/ack)
//   Optional NWAY_CACHE_STATS_EN adds hit_count, miss_count, wb_count (32 bit).
module nway_cache_fsm #(
  parameter int unsigned BLOCK_WORDS = 8,
  parameter int unsigned SETS        = 64,
  parameter int unsigned ASSOC       = 4,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic            clock,
  input  logic            reset,
  nway_cache_fsm_if.slave bus
`ifdef NWAY_CACHE_STATS_EN
  ,
  output logic [31:0]     hit_count,
  output logic [31:0]     miss_count,
  output logic [31:0]     wb_count
`endif
);
  localparam int unsigned OFF_W = $clog2(BLOCK_WORDS);
  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned WAY_W = $clog2(ASSOC);
  localparam int unsigned TAG_W = ADDR_W - 2 - IDX_W - OFF_W;
  localparam int unsigned BLK_W = BLOCK_WORDS * 32;

  typedef enum logic [1:0] {IDLE, LOOKUP, WB, REFILL} state_e;
  state_e state_q, state_d;

  logic [ADDR_W-1:2] addr_q;
  logic              we_q;
  logic [3:0]        mask_q;
  logic [31:0]       wdata_q;
  logic [WAY_W-1:0]  victim_q;

  logic             valid_q [SETS][ASSOC];
  logic             dirty_q [SETS][ASSOC];
  logic [TAG_W-1:0] tag_q   [SETS][ASSOC];
  logic [WAY_W-1:0] lru_q   [SETS][ASSOC];
  logic [BLK_W-1:0] data_q  [SETS][ASSOC];

  logic [OFF_W-1:0] off;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             unused_addr_lsb;

  assign off = addr_q[2 +: OFF_W];
  assign idx = addr_q[2+OFF_W +: IDX_W];
  assign tag = addr_q[ADDR_W-1 -: TAG_W];
  assign unused_addr_lsb = ^bus.cpu_addr[1:0];

  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] vic_way;
  logic [BLK_W-1:0] hit_blk;
  logic [BLK_W-1:0] merged_blk;
  logic [31:0]      hit_word;
  logic [31:0]      merged_word;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    vic_way = '0;
    for (int unsigned w = 0; w < ASSOC; w++) begin
      if (valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (lru_q[idx][w] == WAY_W'(ASSOC - 1)) vic_way = WAY_W'(w);
    end
    // Descending scan so the lowest-index invalid way wins over the LRU way.
    for (int unsigned w = ASSOC; w > 0; w--) begin
      if (!valid_q[idx][w-1]) vic_way = WAY_W'(w - 1);
    end
    hit_blk     = data_q[idx][hit_way];
    hit_word    = hit_blk[{off, 5'b0} +: 32];
    merged_word = hit_word;
    for (int unsigned b = 0; b < 4; b++) begin
      if (mask_q[b]) merged_word[8*b +: 8] = wdata_q[8*b +: 8];
    end
    merged_blk = hit_blk;
    merged_blk[{off, 5'b0} +: 32] = merged_word;
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    bus.cpu_ready  = 1'b0;
    bus.cpu_rdata  = '0;
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wblock = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.cpu_req) state_d = LOOKUP;
      end
      LOOKUP: begin
        if (hit) begin
          bus.cpu_ready = 1'b1;
          bus.cpu_rdata = hit_word;
          state_d       = IDLE;
        end else if (valid_q[idx][vic_way] && dirty_q[idx][vic_way]) begin
          state_d = WB;
        end else begin
          state_d = REFILL;
        end
      end
      WB: begin
        bus.mem_req    = 1'b1;
        bus.mem_we     = 1'b1;
        bus.mem_addr   = {tag_q[idx][victim_q], idx, {(OFF_W+2){1'b0}}};
        bus.mem_wblock = data_q[idx][victim_q];
        if (bus.mem_ack) state_d = REFILL;
      end
      REFILL: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = {tag, idx, {(OFF_W+2){1'b0}}};
        if (bus.mem_ack) state_d = LOOKUP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q   <= '0;
      we_q     <= 1'b0;
      mask_q   <= '0;
      wdata_q  <= '0;
      victim_q <= '0;
    end else begin
      if (state_q == IDLE && bus.cpu_req) begin
        addr_q  <= bus.cpu_addr[ADDR_W-1:2];
        we_q    <= bus.cpu_we;
        mask_q  <= bus.cpu_byte_mask;
        wdata_q <= bus.cpu_wdata;
      end
      if (state_q == LOOKUP && !hit) victim_q <= vic_way;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        for (int unsigned w = 0; w < ASSOC; w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
          lru_q[s][w]   <= WAY_W'(w);
        end
      end
    end else begin
      unique case (state_q)
        LOOKUP: begin
          if (hit) begin
            if (we_q) begin
              data_q[idx][hit_way]  <= merged_blk;
              dirty_q[idx][hit_way] <= 1'b1;
            end
            // Hit way becomes MRU; ways younger than it age by one.
            for (int unsigned w = 0; w < ASSOC; w++) begin
              if (WAY_W'(w) == hit_way)
                lru_q[idx][w] <= '0;
              else if (lru_q[idx][w] < lru_q[idx][hit_way])
                lru_q[idx][w] <= lru_q[idx][w] + 1'b1;
            end
          end
        end
        WB: begin
          if (bus.mem_ack) valid_q[idx][victim_q] <= 1'b0;
        end
        REFILL: begin
          if (bus.mem_ack) begin
            data_q[idx][victim_q]  <= bus.mem_rblock;
            tag_q[idx][victim_q]   <= tag;
            valid_q[idx][victim_q] <= 1'b1;
            dirty_q[idx][victim_q] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef NWAY_CACHE_STATS_EN
  // refilled_q marks the replay lookup so it is not counted as a second hit.
  logic        refilled_q;
  logic [31:0] hit_q, miss_q, wb_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      refilled_q <= 1'b0;
      hit_q      <= '0;
      miss_q     <= '0;
      wb_q       <= '0;
    end else begin
      if (state_q == IDLE && bus.cpu_req)     refilled_q <= 1'b0;
      if (state_q == REFILL && bus.mem_ack)   refilled_q <= 1'b1;
      if (state_q == LOOKUP) begin
        if (!hit)             miss_q <= miss_q + 32'd1;
        else if (!refilled_q) hit_q  <= hit_q + 32'd1;
      end
      if (state_q == WB && bus.mem_ack)       wb_q <= wb_q + 32'd1;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
  assign wb_count   = wb_q;
`endif
endmodule

// File: tb/tb_nway_cache_fsm.sv
// tb_nway_cache_fsm: randomized self-checking bench for nway_cache_fsm.
// The reference is a flat word memory (what loads must return) plus a
// per-set recency-ordered line list (which accesses miss / write back).
module tb_nway_cache_fsm;
  localparam int unsigned BLOCK_WORDS = 8;
  localparam int unsigned SETS        = 64;
  localparam int unsigned ASSOC       = 4;
  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned OFF_W       = $clog2(BLOCK_WORDS);
  localparam int unsigned IDX_W       = $clog2(SETS);
  localparam int unsigned BW          = BLOCK_WORDS * 32;

  logic clock = 1'b0;
  logic reset = 1'b1;

  nway_cache_fsm_if #(.BLOCK_WORDS(BLOCK_WORDS), .ADDR_W(ADDR_W)) bus ();

`ifdef NWAY_CACHE_STATS_EN
  logic [31:0] hit_count, miss_count, wb_count;
`endif

  nway_cache_fsm #(
    .BLOCK_WORDS(BLOCK_WORDS),
    .SETS       (SETS),
    .ASSOC      (ASSOC),
    .ADDR_W     (ADDR_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
`ifdef NWAY_CACHE_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count),
    .wb_count  (wb_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    int unsigned tag;
    bit          dirty;
  } line_t;

  line_t       lines [SETS][$];        // front = most recently used
  logic [31:0] arch  [int unsigned];   // architectural word values
  logic [31:0] mem   [int unsigned];   // next-level memory contents
  int unsigned total, bad;
  int unsigned m_hits, m_miss, m_wb;

  task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int unsigned wi);
    return wi + 32'hF0;
  endfunction

  function automatic logic [31:0] mem_rd(input int unsigned wi);
    return mem.exists(wi) ? mem[wi] : init_word(wi);
  endfunction

  function automatic logic [31:0] arch_rd(input int unsigned wi);
    return arch.exists(wi) ? arch[wi] : init_word(wi);
  endfunction

  function automatic logic [BW-1:0] mem_block(input int unsigned base);
    logic [BW-1:0] b;
    for (int unsigned w = 0; w < BLOCK_WORDS; w++) b[32*w +: 32] = mem_rd(base + w);
    return b;
  endfunction

  task automatic model_reset();
    for (int unsigned s = 0; s < SETS; s++) lines[s].delete();
    arch.delete();
    foreach (mem[k]) arch[k] = mem[k];   // dirty cached data is lost
    m_hits = 0;
    m_miss = 0;
    m_wb   = 0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    bus.cpu_req = 1'b0;
    bus.mem_ack = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic access(input bit we, input logic [ADDR_W-1:0] addr, input logic [3:0] mask,
                        input logic [31:0] wdata, input int unsigned wdly, input int unsigned rdly);
    int unsigned   idx, tag, wi, pos, exp_lat, cycles, wcnt, base;
    bit            hit_e, wb_e, wb_done, rf_done, done, exp_we;
    logic [ADDR_W-1:0] blk_addr, wb_addr;
    logic [BW-1:0] wb_blk;
    logic [31:0]   exp_rd, merged;
    line_t         ln, vic;

    idx      = (addr >> (OFF_W + 2)) % SETS;
    tag      = addr >> (OFF_W + 2 + IDX_W);
    wi       = addr >> 2;
    blk_addr = addr & ~ADDR_W'(BLOCK_WORDS * 4 - 1);
    hit_e = 1'b0; pos = 0; wb_e = 1'b0; wb_addr = '0; wb_blk = '0;
    for (int unsigned i = 0; i < lines[idx].size(); i++)
      if (lines[idx][i].tag == tag) begin hit_e = 1'b1; pos = i; end
    if (hit_e) begin
      ln = lines[idx][pos];
      lines[idx].delete(pos);
      m_hits++;
    end else begin
      m_miss++;
      ln.tag = tag;
      ln.dirty = 1'b0;
      if (lines[idx].size() == ASSOC) begin
        vic = lines[idx].pop_back();
        if (vic.dirty) begin
          wb_e = 1'b1;
          m_wb++;
          wb_addr = ADDR_W'((vic.tag << (OFF_W + 2 + IDX_W)) | (idx << (OFF_W + 2)));
          for (int unsigned w = 0; w < BLOCK_WORDS; w++)
            wb_blk[32*w +: 32] = arch_rd((wb_addr >> 2) + w);
        end
      end
    end
    if (we) ln.dirty = 1'b1;
    lines[idx].push_front(ln);
    exp_rd = arch_rd(wi);
    if (we) begin
      merged = exp_rd;
      for (int unsigned b = 0; b < 4; b++) if (mask[b]) merged[8*b +: 8] = wdata[8*b +: 8];
      arch[wi] = merged;
    end
    exp_lat = hit_e ? 1 : 3 + rdly + (wb_e ? 1 + wdly : 0);

    @(negedge clock);
    chk("idle_ready",    BW'(bus.cpu_ready), BW'(0));
    chk("idle_mem_req",  BW'(bus.mem_req),   BW'(0));
    chk("idle_mem_addr", BW'(bus.mem_addr),  BW'(0));
    bus.cpu_req = 1'b1;
    bus.cpu_we = we;
    bus.cpu_addr = addr;
    bus.cpu_byte_mask = mask;
    bus.cpu_wdata = wdata;
    cycles = 0; wcnt = 0; done = 1'b0; wb_done = 1'b0; rf_done = 1'b0;
    while (!done && cycles < 60) begin
      @(negedge clock);
      cycles++;
      bus.mem_ack = 1'b0;
      if (bus.cpu_ready) begin
        done = 1'b1;
        bus.cpu_req = 1'b0;
        chk("latency", BW'(cycles), BW'(exp_lat));
        if (!we) chk("rdata", BW'(bus.cpu_rdata), BW'(exp_rd));
        chk("wb_seen",     BW'(wb_done), BW'(wb_e));
        chk("refill_seen", BW'(rf_done), BW'(!hit_e));
      end else if (bus.mem_req) begin
        exp_we = wb_e && !wb_done;
        if (hit_e) chk("mem_req_on_hit", BW'(hit_e), BW'(0));
        chk("mem_we",   BW'(bus.mem_we),   BW'(exp_we));
        chk("mem_addr", BW'(bus.mem_addr), BW'(exp_we ? wb_addr : blk_addr));
        if (exp_we) chk("mem_wblock", bus.mem_wblock, wb_blk);
        if (wcnt == (exp_we ? wdly : rdly)) begin
          bus.mem_ack = 1'b1;
          wcnt = 0;
          base = bus.mem_addr >> 2;
          if (bus.mem_we) begin
            for (int unsigned w = 0; w < BLOCK_WORDS; w++) mem[base + w] = bus.mem_wblock[32*w +: 32];
            wb_done = 1'b1;
          end else begin
            bus.mem_rblock = mem_block(base);
            rf_done = 1'b1;
          end
        end else begin
          wcnt++;
        end
      end
    end
    if (!done) begin
      chk("timeout", BW'(done), BW'(1));
      bus.cpu_req = 1'b0;
      bus.mem_ack = 1'b0;
    end
  endtask

`ifdef NWAY_CACHE_STATS_EN
  task automatic chk_stats();
    chk("hit_count",  BW'(hit_count),  BW'(m_hits));
    chk("miss_count", BW'(miss_count), BW'(m_miss));
    chk("wb_count",   BW'(wb_count),   BW'(m_wb));
  endtask
`endif

  initial begin
    bit                seen;
    bit                r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_mask;
    logic [31:0]       r_wdata;

    total = 0; bad = 0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0;
    bus.cpu_byte_mask = '0; bus.cpu_wdata = '0;
    bus.mem_rblock = '0; bus.mem_ack = 1'b0;

    do_reset();
    chk("rst_cpu_ready",  BW'(bus.cpu_ready),  BW'(0));
    chk("rst_cpu_rdata",  BW'(bus.cpu_rdata),  BW'(0));
    chk("rst_mem_req",    BW'(bus.mem_req),    BW'(0));
    chk("rst_mem_we",     BW'(bus.mem_we),     BW'(0));
    chk("rst_mem_addr",   BW'(bus.mem_addr),   BW'(0));
    chk("rst_mem_wblock", bus.mem_wblock,      BW'(0));

    // Cold read, masked store hit, eviction with write-back.
    access(1'b0, 32'h40, 4'h0, 32'h0, 0, 0);
    access(1'b0, 32'h44, 4'h0, 32'h0, 0, 0);
    access(1'b1, 32'h44, 4'b0011, 32'hAABBCCDD, 0, 0);
    access(1'b0, 32'h44, 4'h0, 32'h0, 0, 0);
    access(1'b0, 32'h840,  4'h0, 32'h0, 0, 0);
    access(1'b0, 32'h1040, 4'h0, 32'h0, 0, 0);
    access(1'b0, 32'h1840, 4'h0, 32'h0, 0, 0);
    access(1'b0, 32'h2040, 4'h0, 32'h0, 1, 2);
`ifdef NWAY_CACHE_STATS_EN
    chk_stats();
`endif

    // Slow memory, then an empty-mask store whose line must still write back.
    access(1'b0, 32'h2844, 4'h0, 32'h0, 0, 5);
    access(1'b1, 32'h848, 4'b0000, 32'hFFFFFFFF, 0, 0);
    access(1'b0, 32'h3040, 4'h0, 32'h0, 0, 0);
    access(1'b0, 32'h3840, 4'h0, 32'h0, 0, 0);
    access(1'b0, 32'h4040, 4'h0, 32'h0, 0, 0);
    access(1'b0, 32'h4840, 4'h0, 32'h0, 2, 0);

    for (int unsigned n = 0; n < 400; n++) begin
      r_we    = 1'($urandom_range(0, 1));
      r_addr  = ADDR_W'(($urandom_range(0, 5) << (OFF_W + 2 + IDX_W)) |
                        ($urandom_range(0, 3) << (OFF_W + 2)) |
                        ($urandom_range(0, BLOCK_WORDS - 1) << 2) |
                        $urandom_range(0, 3));
      r_mask  = 4'($urandom);
      r_wdata = $urandom;
      access(r_we, r_addr, r_mask, r_wdata, $urandom_range(0, 3), $urandom_range(0, 3));
    end
`ifdef NWAY_CACHE_STATS_EN
    chk_stats();
`endif

    // Reset while a refill is outstanding.
    do_reset();
    @(negedge clock);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h40;
    bus.cpu_byte_mask = 4'h0; bus.cpu_wdata = '0;
    seen = 1'b0;
    for (int unsigned c = 0; c < 10 && !seen; c++) begin
      @(negedge clock);
      if (bus.mem_req) seen = 1'b1;
    end
    chk("rst_refill_reached", BW'(seen), BW'(1));
    @(negedge clock);
    reset = 1'b1;
    bus.cpu_req = 1'b0;
    @(negedge clock);
    chk("midrst_mem_req",    BW'(bus.mem_req),   BW'(0));
    chk("midrst_mem_we",     BW'(bus.mem_we),    BW'(0));
    chk("midrst_mem_addr",   BW'(bus.mem_addr),  BW'(0));
    chk("midrst_mem_wblock", bus.mem_wblock,     BW'(0));
    chk("midrst_cpu_ready",  BW'(bus.cpu_ready), BW'(0));
    chk("midrst_cpu_rdata",  BW'(bus.cpu_rdata), BW'(0));
    reset = 1'b0;
    model_reset();
    access(1'b0, 32'h40, 4'h0, 32'h0, 0, 1);
`ifdef NWAY_CACHE_STATS_EN
    chk_stats();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
